ifetch_assoc: RTL

//  Parametrised instruction-fetch unit: N-way set-associative iCache (1 or 2 ways, LRU) with

---
 rtl/ifetch_assoc.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/ifetch_assoc.sv
// Instruction fetch: set-associative iCache (1 or 2 ways, LRU), whole-line refill from memctrl,
// bimodal 2-bit branch predictor, one instruction per cycle to the decoder.
module ifetch_assoc #(
    parameter int ADDR_W      = 32,
    parameter int LINE_BYTES  = 64,
    parameter int SETS        = 8,
    parameter int WAYS        = 2,
    parameter int BHT_ENTRIES = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    rs_full,
    input  logic                    lsb_full,
    input  logic                    rob_full,
    output logic                    decode_inst_rdy,
    output logic [31:0]             decode_inst,
    output logic [ADDR_W-1:0]       decode_inst_pc,
    output logic                    decode_inst_pre_jump,
    output logic                    memc_en,
    output logic [ADDR_W-1:0]       memc_pc,
    input  logic                    memc_done,
    input  logic [LINE_BYTES*8-1:0] memc_data,
    input  logic                    rob_set_pc_en,
    input  logic [ADDR_W-1:0]       rob_set_pc,
    input  logic                    rob_br,
    input  logic                    rob_br_jump,
    input  logic [ADDR_W-1:0]       rob_br_pc
);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int WORD_W = OFF_W - 2;
    localparam int SET_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - OFF_W - SET_W;
    localparam int BHT_W  = $clog2(BHT_ENTRIES);
    localparam int LINE_W = LINE_BYTES * 8;

    generate
        if (WAYS != 1 && WAYS != 2) begin : g_bad_ways
            $error("ifetch_assoc: WAYS must be 1 or 2");
        end
    endgenerate

    typedef enum logic {IDLE, FILL} state_t;
    state_t state, state_next;

    logic [ADDR_W-1:0] pc;
    logic [LINE_W-1:0] line_data [WAYS][SETS];
    logic [TAG_W-1:0]  tag_mem   [WAYS][SETS];
    logic [WAYS-1:0]   valid     [SETS];
    logic [SETS-1:0]   lru;
    logic [1:0]        bht       [BHT_ENTRIES];

    logic [WORD_W-1:0] pc_word;
    logic [SET_W-1:0]  pc_set, fill_set;
    logic [TAG_W-1:0]  pc_tag, fill_tag;
    logic [BHT_W-1:0]  bht_idx, br_idx;

    assign pc_word  = pc[OFF_W-1:2];
    assign pc_set   = pc[OFF_W+SET_W-1:OFF_W];
    assign pc_tag   = pc[ADDR_W-1:OFF_W+SET_W];
    assign fill_set = memc_pc[OFF_W+SET_W-1:OFF_W];
    assign fill_tag = memc_pc[ADDR_W-1:OFF_W+SET_W];
    assign bht_idx  = pc[BHT_W+1:2];
    assign br_idx   = rob_br_pc[BHT_W+1:2];

    logic unused_br_bits;
    assign unused_br_bits = ^{rob_br_pc[ADDR_W-1:BHT_W+2], rob_br_pc[1:0]};

    logic              hit, hit_way, victim, stall;
    logic [LINE_W-1:0] hit_line;
    logic [31:0]       inst;
    logic [ADDR_W-1:0] j_imm, b_imm, pred_pc;
    logic              pred_jump;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        hit     = 1'b0;
        hit_way = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[pc_set][w] && tag_mem[w][pc_set] == pc_tag) begin
                hit     = 1'b1;
                hit_way = 1'(w);
            end
        end
    end

    assign hit_line = line_data[hit_way][pc_set];
    assign inst     = hit_line[{pc_word, 5'b0} +: 32];
    assign stall    = rs_full | lsb_full | rob_full;

    assign j_imm = {{(ADDR_W-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    assign b_imm = {{(ADDR_W-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};

    always_comb begin
        pred_pc   = pc + ADDR_W'(4);
        pred_jump = 1'b0;
        case (inst[6:0])
            7'b1101111: begin
                pred_pc   = pc + j_imm;
                pred_jump = 1'b1;
            end
            7'b1100011: begin
                if (bht[bht_idx] >= 2'd2) begin
                    pred_pc   = pc + b_imm;
                    pred_jump = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Victim: first invalid way (way 0 preferred), otherwise the LRU way.
    always_comb begin
        if (WAYS == 1 || !valid[fill_set][0])
            victim = 1'b0;
        else if (!valid[fill_set][WAYS-1])
            victim = 1'b1;
        else
            victim = lru[fill_set];
    end

    logic fill_start, fill_done;

    always_comb begin
        state_next = state;
        fill_start = 1'b0;
        fill_done  = 1'b0;
        case (state)
            IDLE: if (!hit) begin
                state_next = FILL;
                fill_start = 1'b1;
            end
            FILL: if (memc_done) begin
                state_next = IDLE;
                fill_done  = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else if (rdy)
            state <= state_next;
    end

    // NOTE: line data and tags carry no reset; the cleared valid bits make their contents irrelevant.
    always_ff @(posedge clk) begin
        if (rdy && fill_done) begin
            line_data[victim][fill_set] <= memc_data;
            tag_mem[victim][fill_set]   <= fill_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc                   <= '0;
            decode_inst_rdy      <= 1'b0;
            decode_inst          <= '0;
            decode_inst_pc       <= '0;
            decode_inst_pre_jump <= 1'b0;
            memc_en              <= 1'b0;
            memc_pc              <= '0;
            lru                  <= '0;
            for (int s = 0; s < SETS; s++) valid[s] <= '0;
            for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'd0;
        end else if (rdy) begin
            if (rob_set_pc_en) begin
                pc              <= rob_set_pc;
                decode_inst_rdy <= 1'b0;
            end else if (hit && !stall) begin
                decode_inst_rdy      <= 1'b1;
                decode_inst          <= inst;
                decode_inst_pc       <= pc;
                decode_inst_pre_jump <= pred_jump;
                pc                   <= pred_pc;
                if (WAYS == 2) lru[pc_set] <= ~hit_way;
            end else begin
                decode_inst_rdy <= 1'b0;
            end

            if (fill_start) begin
                memc_en <= 1'b1;
                memc_pc <= {pc[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            end
            // Install is applied after the issue path so its LRU update wins on a shared set.
            if (fill_done) begin
                memc_en                  <= 1'b0;
                valid[fill_set][victim]  <= 1'b1;
                if (WAYS == 2) lru[fill_set] <= ~victim;
            end

            if (rob_br) begin
                if (rob_br_jump && bht[br_idx] != 2'd3)
                    bht[br_idx] <= bht[br_idx] + 2'd1;
                else if (!rob_br_jump && bht[br_idx] != 2'd0)
                    bht[br_idx] <= bht[br_idx] - 2'd1;
            end
        end
    end
endmodule
